safebox_lock_ctrl: RTL and testbench
====================================

SAFEBOX_LOCK_CTRL -- requirements
Module: safebox_lock_ctrl

Interface
REQ-001 The block SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning the code loaded at reset as 4 BCD digits, most significant digit entered first.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, meaning the consecutive failed attempts that trigger lockout (legal range 1..3).
REQ-003 The block SHALL have parameter OPEN_CYCLES, default 500_000_000, meaning the auto-relock timeout in clk cycles.
REQ-004 The block SHALL have parameter LOCKOUT_CYCLES, default 1_500_000_000, meaning the lockout duration in clk cycles.
REQ-005 The block SHALL have port clk, input, width 1: the single clock, rising-edge active.
REQ-006 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port key_pulse, input, width 1: single-cycle key event, already pulse-shortened upstream.
REQ-008 The block SHALL have port key_code, input, width 4, with these meanings:
- 0-9: digit
- 10: ENTER
- 11: CLEAR
- 12: PROGRAM
- 13-15: ignored
REQ-009 The block SHALL have port locked, output, width 1: bolt engaged.
REQ-010 The block SHALL have port open, output, width 1: bolt released.
REQ-011 The block SHALL have port alarm, output, width 1: lockout active.
REQ-012 The block SHALL have port digit_cnt, output, width 3: digits currently buffered (0..4).
REQ-013 The block SHALL have port fail_cnt, output, width 2: consecutive failures.
REQ-014 The block SHALL have port state, output, width 3, with these encodings:
- 0: LOCKED
- 1: CHECK
- 2: OPEN
- 3: PROGRAM
- 4: LOCKOUT

Function
REQ-015 The block SHALL sample key_code only in cycles where key_pulse=1, and SHALL treat each such cycle as one key event.
REQ-016 On every accepted digit with digit_cnt<4, the block SHALL update buf to {buf[11:0],digit} and increment digit_cnt.
- Applies in LOCKED and PROGRAM.
- Digits arriving with digit_cnt=4 SHALL be ignored.
REQ-017 In LOCKED, CLEAR SHALL set buf=0 and digit_cnt=0; PROGRAM SHALL be ignored.
REQ-018 In LOCKED, ENTER SHALL move the FSM to CHECK on the next edge, regardless of digit_cnt. With digit_cnt<4 the attempt SHALL be judged a mismatch.
REQ-019 CHECK SHALL last exactly one cycle. All key events in CHECK SHALL be ignored. On exit, buf and digit_cnt SHALL be cleared.
REQ-020 From CHECK on a match (digit_cnt=4 and buf=code), the FSM SHALL go to OPEN, clear fail_cnt and load the open timer with OPEN_CYCLES.
REQ-021 From CHECK on a mismatch, the block SHALL increment fail_cnt.
- If the new fail_cnt equals MAX_FAIL, the FSM SHALL go to LOCKOUT and load the lockout timer with LOCKOUT_CYCLES.
- Otherwise it SHALL return to LOCKED.
REQ-022 In OPEN, the open timer SHALL decrement each cycle and the FSM SHALL go to LOCKED when it reaches 0. If ENTER and timer expiry occur in the same cycle, the result SHALL be LOCKED.
REQ-023 In OPEN, ENTER SHALL relock immediately (next state LOCKED).
REQ-024 In OPEN, PROGRAM SHALL go to PROGRAM with buf=0 and digit_cnt=0.
REQ-025 In OPEN, digits and CLEAR SHALL be ignored.
REQ-026 In PROGRAM, the open timer SHALL be frozen.
REQ-027 In PROGRAM, ENTER with digit_cnt=4 SHALL set code=buf, clear buf and digit_cnt, and return to OPEN with the timer reloaded to OPEN_CYCLES.
REQ-028 In PROGRAM, ENTER with digit_cnt<4 SHALL be ignored.
REQ-029 In PROGRAM, CLEAR SHALL abort: code unchanged, buf and digit_cnt cleared, return to OPEN with the timer reloaded.
REQ-030 In PROGRAM, a PROGRAM key SHALL be ignored.
REQ-031 In LOCKOUT, all keys SHALL be ignored. The lockout timer SHALL decrement each cycle and, on reaching 0, the FSM SHALL go to LOCKED with fail_cnt=0.
REQ-032 All outputs SHALL be registered.
- locked=1 in LOCKED, CHECK and LOCKOUT; 0 otherwise.
- open is the exact complement of locked.
- alarm=1 only in LOCKOUT.
REQ-033 Latency: for ENTER sampled at rising edge N, CHECK SHALL be visible after edge N, and open/locked/alarm SHALL update after edge N+1.
REQ-034 Timers SHALL be 32-bit down-counters and SHALL NOT wrap below 0.

Reset
REQ-035 While rst_n=0, the block SHALL asynchronously force:
- state=LOCKED, code=DEFAULT_CODE
- buf=0, digit_cnt=0, fail_cnt=0, both timers=0
- locked=1, open=0, alarm=0
REQ-036 A reset asserted mid-operation SHALL abort the operation in progress and discard any programmed code. The block SHALL accept keys from the first rising edge after rst_n deasserts.

Verification
REQ-037 The bench SHALL cover: reset, then digits 1,2,3,4 and ENTER -> state 1 for one cycle, then open=1, locked=0, fail_cnt=0.
REQ-038 The bench SHALL cover: digits 1,2,3,5 and ENTER, three times with MAX_FAIL=3 -> fail_cnt 1, then 2, then state=4 with alarm=1. Keys during lockout have no effect. After LOCKOUT_CYCLES (set to 20 in the bench), locked=1, alarm=0, fail_cnt=0.
REQ-039 The bench SHALL cover: in OPEN, PROGRAM, digits 9,8,7,6 and ENTER; then ENTER to relock; then 9,8,7,6 and ENTER -> open=1, while 1,2,3,4 and ENTER -> fail_cnt=1.
REQ-040 The bench SHALL cover: digits 1,2,3,4,5,6 -> digit_cnt saturates at 4 with buf=16'h1234; then CLEAR -> digit_cnt=0; then ENTER -> mismatch, fail_cnt=1.
REQ-041 The bench SHALL cover: OPEN with OPEN_CYCLES=10 and no keys -> locked=1 exactly 10 cycles after entering OPEN; a PROGRAM session spanning 30 cycles does not relock.
REQ-042 The bench SHALL cover: rst_n pulsed low during PROGRAM after digits 5,5 -> locked=1, digit_cnt=0, and code 1,2,3,4 opens.

Source files
------------

// File: rtl/safebox_lock_ctrl.sv
// Keypad safe controller: 4-digit BCD code entry, code reprogramming while open,
// auto-relock timer and a timed lockout after repeated wrong attempts.
module safebox_lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned OPEN_CYCLES    = 500_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pulse,
    input  logic [3:0] key_code,
    output logic       locked,
    output logic       open,
    output logic       alarm,
    output logic [2:0] digit_cnt,
    output logic [1:0] fail_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [3:0]  KEY_ENTER   = 4'd10;
    localparam logic [3:0]  KEY_CLEAR   = 4'd11;
    localparam logic [3:0]  KEY_PROGRAM = 4'd12;
    localparam logic [1:0]  FAIL_LIMIT  = 2'(MAX_FAIL);
    localparam logic [31:0] OPEN_LOAD   = 32'(OPEN_CYCLES);
    localparam logic [31:0] LOCK_LOAD   = 32'(LOCKOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_buf;
    logic [15:0] w_buf_nxt;
    logic [15:0] r_code;
    logic [15:0] w_code_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [1:0]  r_fail;
    logic [1:0]  w_fail_nxt;
    logic [1:0]  w_fail_inc;
    logic [31:0] r_open_tmr;
    logic [31:0] w_open_tmr_nxt;
    logic [31:0] r_lock_tmr;
    logic [31:0] w_lock_tmr_nxt;
    logic        r_locked;
    logic        r_open;
    logic        r_alarm;
    logic        w_locked_nxt;
    logic        w_open_nxt;
    logic        w_alarm_nxt;

    logic w_digit;
    logic w_enter;
    logic w_clear;
    logic w_prog;
    logic w_room;
    logic w_match;

    assign w_digit    = key_pulse && (key_code <= 4'd9);
    assign w_enter    = key_pulse && (key_code == KEY_ENTER);
    assign w_clear    = key_pulse && (key_code == KEY_CLEAR);
    assign w_prog     = key_pulse && (key_code == KEY_PROGRAM);
    assign w_room     = (r_cnt < 3'd4);
    assign w_match    = (r_cnt == 3'd4) && (r_buf == r_code);
    assign w_fail_inc = r_fail + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOCKED;
            r_buf      <= 16'h0000;
            r_code     <= DEFAULT_CODE;
            r_cnt      <= 3'd0;
            r_fail     <= 2'd0;
            r_open_tmr <= 32'd0;
            r_lock_tmr <= 32'd0;
            r_locked   <= 1'b1;
            r_open     <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_code     <= w_code_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fail     <= w_fail_nxt;
            r_open_tmr <= w_open_tmr_nxt;
            r_lock_tmr <= w_lock_tmr_nxt;
            r_locked   <= w_locked_nxt;
            r_open     <= w_open_nxt;
            r_alarm    <= w_alarm_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_code_nxt     = r_code;
        w_cnt_nxt      = r_cnt;
        w_fail_nxt     = r_fail;
        w_open_tmr_nxt = r_open_tmr;
        w_lock_tmr_nxt = r_lock_tmr;

        unique case (r_state)
            ST_LOCKED: begin
                if (w_digit) begin
                    if (w_room) begin
                        w_buf_nxt = {r_buf[11:0], key_code};
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else if (w_clear) begin
                    w_buf_nxt = 16'h0000;
                    w_cnt_nxt = 3'd0;
                end else if (w_enter) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_buf_nxt = 16'h0000;
                w_cnt_nxt = 3'd0;
                if (w_match) begin
                    w_state_nxt    = ST_OPEN;
                    w_fail_nxt     = 2'd0;
                    w_open_tmr_nxt = OPEN_LOAD;
                end else begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == FAIL_LIMIT) begin
                        w_state_nxt    = ST_LOCKOUT;
                        w_lock_tmr_nxt = LOCK_LOAD;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            // Expiry takes priority over any key seen in the same cycle.
            ST_OPEN: begin
                if (r_open_tmr <= 32'd1) begin
                    w_open_tmr_nxt = 32'd0;
                    w_state_nxt    = ST_LOCKED;
                end else begin
                    w_open_tmr_nxt = r_open_tmr - 32'd1;
                    if (w_enter) begin
                        w_open_tmr_nxt = 32'd0;
                        w_state_nxt    = ST_LOCKED;
                    end else if (w_prog) begin
                        w_buf_nxt   = 16'h0000;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_PROGRAM;
                    end
                end
            end
            ST_PROGRAM: begin
                if (w_digit) begin
                    if (w_room) begin
                        w_buf_nxt = {r_buf[11:0], key_code};
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else if (w_enter) begin
                    if (r_cnt == 3'd4) begin
                        w_code_nxt     = r_buf;
                        w_buf_nxt      = 16'h0000;
                        w_cnt_nxt      = 3'd0;
                        w_open_tmr_nxt = OPEN_LOAD;
                        w_state_nxt    = ST_OPEN;
                    end
                end else if (w_clear) begin
                    w_buf_nxt      = 16'h0000;
                    w_cnt_nxt      = 3'd0;
                    w_open_tmr_nxt = OPEN_LOAD;
                    w_state_nxt    = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (r_lock_tmr <= 32'd1) begin
                    w_lock_tmr_nxt = 32'd0;
                    w_fail_nxt     = 2'd0;
                    w_state_nxt    = ST_LOCKED;
                end else begin
                    w_lock_tmr_nxt = r_lock_tmr - 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_LOCKED;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track r_state.
    always_comb begin
        w_locked_nxt = (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_CHECK) ||
                       (w_state_nxt == ST_LOCKOUT);
        w_open_nxt   = ~w_locked_nxt;
        w_alarm_nxt  = (w_state_nxt == ST_LOCKOUT);
    end

    assign locked    = r_locked;
    assign open      = r_open;
    assign alarm     = r_alarm;
    assign digit_cnt = r_cnt;
    assign fail_cnt  = r_fail;
    assign state     = r_state;

endmodule

// File: tb/tb_safebox_lock_ctrl.sv
// Self-checking bench for safebox_lock_ctrl: directed scenarios followed by random
// key sequences, every cycle compared against a queue-based reference model.
module tb_safebox_lock_ctrl;

    localparam int OPEN_CYC = 10;
    localparam int LOCK_CYC = 20;
    localparam int MAXF     = 3;
    localparam int K_ENTER  = 10;
    localparam int K_CLEAR  = 11;
    localparam int K_PROG   = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_pulse;
    logic [3:0] key_code;
    logic       locked;
    logic       open;
    logic       alarm;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;

    string mMode;
    int    mBuf[$];
    int    mCode[4];
    int    mFail;
    int    mOpenLeft;
    int    mLockLeft;

    safebox_lock_ctrl #(
        .DEFAULT_CODE  (16'h1234),
        .MAX_FAIL      (MAXF),
        .OPEN_CYCLES   (OPEN_CYC),
        .LOCKOUT_CYCLES(LOCK_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_pulse(key_pulse),
        .key_code (key_code),
        .locked   (locked),
        .open     (open),
        .alarm    (alarm),
        .digit_cnt(digit_cnt),
        .fail_cnt (fail_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mMode = "LOCKED";
        mBuf.delete();
        mCode     = '{1, 2, 3, 4};
        mFail     = 0;
        mOpenLeft = 0;
        mLockLeft = 0;
    endtask

    function automatic bit codeMatches();
        if (mBuf.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (mBuf[i] != mCode[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the safe's behaviour, given the key seen in that cycle.
    task automatic modelStep(input bit p, input int k);
        if (mMode == "LOCKED") begin
            if (p && k <= 9) begin
                if (mBuf.size() < 4) mBuf.push_back(k);
            end else if (p && k == K_CLEAR) begin
                mBuf.delete();
            end else if (p && k == K_ENTER) begin
                mMode = "CHECK";
            end
        end else if (mMode == "CHECK") begin
            if (codeMatches()) begin
                mFail     = 0;
                mOpenLeft = OPEN_CYC;
                mMode     = "OPEN";
            end else begin
                mFail++;
                if (mFail == MAXF) begin
                    mLockLeft = LOCK_CYC;
                    mMode     = "LOCKOUT";
                end else begin
                    mMode = "LOCKED";
                end
            end
            mBuf.delete();
        end else if (mMode == "OPEN") begin
            mOpenLeft--;
            if (mOpenLeft == 0) mMode = "LOCKED";
            else if (p && k == K_ENTER) mMode = "LOCKED";
            else if (p && k == K_PROG) begin
                mBuf.delete();
                mMode = "PROGRAM";
            end
        end else if (mMode == "PROGRAM") begin
            if (p && k <= 9) begin
                if (mBuf.size() < 4) mBuf.push_back(k);
            end else if (p && k == K_ENTER && mBuf.size() == 4) begin
                for (int i = 0; i < 4; i++) mCode[i] = mBuf[i];
                mBuf.delete();
                mOpenLeft = OPEN_CYC;
                mMode     = "OPEN";
            end else if (p && k == K_CLEAR) begin
                mBuf.delete();
                mOpenLeft = OPEN_CYC;
                mMode     = "OPEN";
            end
        end else begin
            mLockLeft--;
            if (mLockLeft == 0) begin
                mFail = 0;
                mMode = "LOCKED";
            end
        end
    endtask

    function automatic int expState();
        if (mMode == "LOCKED")  return 0;
        if (mMode == "CHECK")   return 1;
        if (mMode == "OPEN")    return 2;
        if (mMode == "PROGRAM") return 3;
        return 4;
    endfunction

    function automatic int expLocked();
        return (mMode == "OPEN" || mMode == "PROGRAM") ? 0 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input int expv);
        vectors++;
        assert (obs === 32'(expv)) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkModel(input string step);
        checkOutput({step, ".state"},     32'(state),     expState());
        checkOutput({step, ".locked"},    32'(locked),    expLocked());
        checkOutput({step, ".open"},      32'(open),      1 - expLocked());
        checkOutput({step, ".alarm"},     32'(alarm),     (mMode == "LOCKOUT") ? 1 : 0);
        checkOutput({step, ".digit_cnt"}, 32'(digit_cnt), mBuf.size());
        checkOutput({step, ".fail_cnt"},  32'(fail_cnt),  mFail);
    endtask

    // Called at a falling edge; drives one cycle of input and checks just after the rising edge.
    task automatic applyStimulus(input bit p, input int k, input string step);
        key_pulse = p;
        key_code  = 4'(k);
        @(posedge clk);
        modelStep(p, k);
        #1;
        checkModel(step);
        @(negedge clk);
        key_pulse = 1'b0;
    endtask

    task automatic pressKey(input int k, input string step);
        applyStimulus(1'b1, k, step);
    endtask

    task automatic idle(input int n, input string step);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, int'($urandom_range(0, 15)), step);
    endtask

    task automatic typeCode(input logic [15:0] code, input string step);
        for (int i = 0; i < 4; i++) pressKey(int'(code[15-4*i -: 4]), step);
    endtask

    task automatic resetPulse(input string step);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkModel(step);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        key_pulse = 1'b0;
        key_code  = 4'd0;
        modelReset();
        #1 rst_n = 1'b0;
        #2 checkModel("reset");
        @(negedge clk);
        rst_n = 1'b1;

        typeCode(16'h1234, "open");
        pressKey(K_ENTER, "open.enter");
        checkOutput("open.check_state", 32'(state), 1);
        idle(1, "open.wait");
        checkOutput("open.open", 32'(open), 1);
        checkOutput("open.locked", 32'(locked), 0);
        checkOutput("open.fail", 32'(fail_cnt), 0);
        pressKey(K_ENTER, "open.relock");

        for (int a = 1; a <= 3; a++) begin
            typeCode(16'h1235, "bad");
            pressKey(K_ENTER, "bad.enter");
            idle(1, "bad.wait");
            if (a < 3) checkOutput("bad.fail", 32'(fail_cnt), a);
            else begin
                checkOutput("bad.lockout_state", 32'(state), 4);
                checkOutput("bad.alarm", 32'(alarm), 1);
            end
        end
        typeCode(16'h1234, "lockout.keys");
        pressKey(K_ENTER, "lockout.keys");
        pressKey(K_PROG, "lockout.keys");
        idle(13, "lockout.wait");
        checkOutput("lockout.still_alarm", 32'(alarm), 1);
        idle(1, "lockout.end");
        checkOutput("lockout.end_locked", 32'(locked), 1);
        checkOutput("lockout.end_alarm", 32'(alarm), 0);
        checkOutput("lockout.end_fail", 32'(fail_cnt), 0);

        typeCode(16'h1234, "prog");
        pressKey(K_ENTER, "prog");
        idle(1, "prog");
        pressKey(K_PROG, "prog.key");
        checkOutput("prog.state", 32'(state), 3);
        typeCode(16'h9876, "prog.digits");
        pressKey(K_ENTER, "prog.commit");
        checkOutput("prog.back_open", 32'(state), 2);
        pressKey(K_ENTER, "prog.relock");
        typeCode(16'h9876, "newcode");
        pressKey(K_ENTER, "newcode");
        idle(1, "newcode");
        checkOutput("newcode.open", 32'(open), 1);
        pressKey(K_ENTER, "newcode.relock");
        typeCode(16'h1234, "oldcode");
        pressKey(K_ENTER, "oldcode");
        idle(1, "oldcode");
        checkOutput("oldcode.fail", 32'(fail_cnt), 1);

        typeCode(16'h9876, "midrst");
        pressKey(K_ENTER, "midrst");
        idle(1, "midrst");
        pressKey(K_PROG, "midrst.prog");
        pressKey(5, "midrst.d");
        pressKey(5, "midrst.d");
        checkOutput("midrst.cnt_before", 32'(digit_cnt), 2);
        resetPulse("midrst.reset");
        checkOutput("midrst.locked", 32'(locked), 1);
        checkOutput("midrst.cnt", 32'(digit_cnt), 0);
        typeCode(16'h1234, "midrst.default");
        pressKey(K_ENTER, "midrst.default");
        idle(1, "midrst.default");
        checkOutput("midrst.default_open", 32'(open), 1);
        pressKey(K_ENTER, "midrst.relock");

        for (int d = 1; d <= 6; d++) pressKey(d, "sat");
        checkOutput("sat.cnt", 32'(digit_cnt), 4);
        pressKey(K_ENTER, "sat.enter");
        idle(1, "sat.wait");
        checkOutput("sat.buf_1234_opens", 32'(open), 1);
        pressKey(K_ENTER, "sat.relock");
        for (int d = 1; d <= 6; d++) pressKey(d, "clr");
        pressKey(K_CLEAR, "clr.clear");
        checkOutput("clr.cnt", 32'(digit_cnt), 0);
        pressKey(K_ENTER, "clr.enter");
        idle(1, "clr.wait");
        checkOutput("clr.fail", 32'(fail_cnt), 1);

        typeCode(16'h1234, "timer");
        pressKey(K_ENTER, "timer");
        idle(1, "timer.enter_open");
        for (int i = 1; i <= OPEN_CYC; i++) begin
            idle(1, "timer.count");
            if (i < OPEN_CYC) checkOutput("timer.still_open", 32'(open), 1);
            else checkOutput("timer.relocked", 32'(locked), 1);
        end
        typeCode(16'h1234, "freeze");
        pressKey(K_ENTER, "freeze");
        idle(1, "freeze");
        pressKey(K_PROG, "freeze.prog");
        idle(30, "freeze.hold");
        checkOutput("freeze.still_prog", 32'(state), 3);
        pressKey(K_CLEAR, "freeze.abort");
        checkOutput("freeze.abort_open", 32'(state), 2);
        idle(OPEN_CYC, "freeze.expire");
        checkOutput("freeze.expired", 32'(locked), 1);

        resetPulse("rand.reset");
        for (int it = 0; it < 80; it++) begin
            int sel;
            int cur[4];
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: begin
                    cur = mCode;
                    for (int i = 0; i < 4; i++) pressKey(cur[i], "rand.good");
                    pressKey(K_ENTER, "rand.good");
                end
                1: begin
                    for (int i = 0; i < 4; i++) pressKey(int'($urandom_range(0, 9)), "rand.digits");
                    pressKey(K_ENTER, "rand.digits");
                end
                2: pressKey(int'($urandom_range(0, 15)), "rand.key");
                3: idle(int'($urandom_range(1, 12)), "rand.idle");
                4: pressKey(K_PROG, "rand.prog");
                5: pressKey(K_CLEAR, "rand.clear");
                default: resetPulse("rand.reset");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
